// File: rtl/dtm_tap_dmi.sv
// dtm_tap_dmi: IEEE 1149.1 TAP with BYPASS/IDCODE/DTMCS/DMI chains and the TCK-side
// DMI request/response handshake with sticky busy/failed status.
module dtm_tap_dmi #(
    parameter int          ABITS        = 7,
    parameter int          IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001,
    parameter logic [2:0]  IDLE_HINT    = 3'd5,
    parameter int          DR_MAX       = ABITS + 34
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op,
    output logic             dmi_hard_reset
);
    localparam int SW = DR_MAX > IR_WIDTH ? DR_MAX : IR_WIDTH;
    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(5'h01);
    localparam logic [IR_WIDTH-1:0] IR_DTMCS  = IR_WIDTH'(5'h10);
    localparam logic [IR_WIDTH-1:0] IR_DMI    = IR_WIDTH'(5'h11);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t          state, state_n;
    logic [IR_WIDTH-1:0] ir;
    logic [SW-1:0]       shift, shift_n;
    logic [1:0]          sticky, sticky_r;
    logic                outstanding, busy, req_fire, resp_fire;
    logic [ABITS-1:0]    last_addr, upd_addr;
    logic [31:0]         last_data, cap_data, upd_data, dtmcs_cap;
    logic [1:0]          upd_op;
    logic                sel_idcode, sel_dtmcs, sel_dmi;
    logic                dmi_cap, dmi_upd, dtmcs_upd;
    int                  dr_len;

    always_comb begin
        state_n = TLR;
        case (state)
            TLR:     state_n = TMS ? TLR    : RTI;
            RTI:     state_n = TMS ? SEL_DR : RTI;
            SEL_DR:  state_n = TMS ? SEL_IR : CAP_DR;
            CAP_DR:  state_n = TMS ? EX1_DR : SH_DR;
            SH_DR:   state_n = TMS ? EX1_DR : SH_DR;
            EX1_DR:  state_n = TMS ? UPD_DR : PA_DR;
            PA_DR:   state_n = TMS ? EX2_DR : PA_DR;
            EX2_DR:  state_n = TMS ? UPD_DR : SH_DR;
            UPD_DR:  state_n = TMS ? SEL_DR : RTI;
            SEL_IR:  state_n = TMS ? TLR    : CAP_IR;
            CAP_IR:  state_n = TMS ? EX1_IR : SH_IR;
            SH_IR:   state_n = TMS ? EX1_IR : SH_IR;
            EX1_IR:  state_n = TMS ? UPD_IR : PA_IR;
            PA_IR:   state_n = TMS ? EX2_IR : PA_IR;
            EX2_IR:  state_n = TMS ? UPD_IR : SH_IR;
            UPD_IR:  state_n = TMS ? SEL_DR : RTI;
            default: state_n = TLR;
        endcase
    end

    assign sel_idcode = ir == IR_IDCODE;
    assign sel_dtmcs  = ir == IR_DTMCS;
    assign sel_dmi    = ir == IR_DMI;
    assign dmi_cap    = sel_dmi && state == CAP_DR;
    assign dmi_upd    = sel_dmi && state == UPD_DR;
    assign dtmcs_upd  = sel_dtmcs && state == UPD_DR;
    assign dr_len     = sel_dmi ? DR_MAX : (sel_idcode || sel_dtmcs) ? 32 : 1;

    assign upd_op   = shift[1:0];
    assign upd_data = shift[33:2];
    assign upd_addr = shift[ABITS+33:34];

    assign req_fire       = dmi_req_valid & dmi_req_ready;
    assign dmi_resp_ready = outstanding & ~dmi_req_valid;
    assign resp_fire      = dmi_resp_valid & dmi_resp_ready;
    // A response landing this cycle retires the transaction before capture/update look at it.
    assign busy      = outstanding & ~resp_fire;
    assign sticky_r  = (resp_fire && dmi_resp_op != 2'd0 && sticky == 2'd0) ? 2'd2 : sticky;
    assign cap_data  = resp_fire ? dmi_resp_data : last_data;
    assign dtmcs_cap = {17'd0, IDLE_HINT, sticky_r, 6'(ABITS), 4'd1};

    assign TDO = (state == SH_DR || state == SH_IR) && shift[0];

    always_comb begin
        shift_n = shift;
        if (state == CAP_IR)
            shift_n = SW'(2'b01);
        else if (state == SH_IR)
            shift_n = (shift >> 1) | (SW'(TDI) << (IR_WIDTH - 1));
        else if (state == CAP_DR)
            shift_n = sel_dmi    ? SW'({last_addr, cap_data, busy ? 2'b11 : sticky_r}) :
                      sel_idcode ? SW'(IDCODE_VALUE) :
                      sel_dtmcs  ? SW'(dtmcs_cap) : '0;
        else if (state == SH_DR)
            shift_n = (shift >> 1) | (SW'(TDI) << (dr_len - 1));
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state          <= TLR;
            ir             <= IR_IDCODE;
            shift          <= '0;
            sticky         <= 2'd0;
            outstanding    <= 1'b0;
            last_addr      <= '0;
            last_data      <= '0;
            dmi_req_valid  <= 1'b0;
            dmi_req_addr   <= '0;
            dmi_req_data   <= '0;
            dmi_req_op     <= 2'd0;
            dmi_hard_reset <= 1'b0;
        end else begin
            state          <= state_n;
            ir             <= state_n == TLR ? IR_IDCODE : state == UPD_IR ? shift[IR_WIDTH-1:0] : ir;
            shift          <= shift_n;
            sticky         <= sticky_r;
            dmi_hard_reset <= 1'b0;
            if (req_fire)
                dmi_req_valid <= 1'b0;
            if (resp_fire) begin
                last_data   <= dmi_resp_data;
                outstanding <= 1'b0;
            end
            if ((dmi_cap || dmi_upd) && busy && sticky_r == 2'd0)
                sticky <= 2'd3;
            if (dmi_upd && !busy && sticky_r == 2'd0 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
                dmi_req_valid <= 1'b1;
                dmi_req_addr  <= upd_addr;
                dmi_req_data  <= upd_data;
                dmi_req_op    <= upd_op;
                outstanding   <= 1'b1;
                last_addr     <= upd_addr;
            end
            if (dtmcs_upd && (shift[16] || shift[17]))
                sticky <= 2'd0;
            // dmihardreset abandons the transaction even if its response arrives this cycle.
            if (dtmcs_upd && shift[17]) begin
                outstanding    <= 1'b0;
                dmi_req_valid  <= 1'b0;
                dmi_hard_reset <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dtm_tap_dmi.sv
// tb_dtm_tap_dmi: directed JTAG scans against dtm_tap_dmi with a queue of expected results.
module tb_dtm_tap_dmi;
    localparam logic [31:0] IDC = 32'h1BE5_6A3D;

    logic        TCK = 1'b0;
    logic        TRST, TMS, TDI, TDO;
    logic        dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready, dmi_hard_reset;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data, dmi_resp_data;
    logic [1:0]  dmi_req_op, dmi_resp_op;

    string       tags[$];
    logic [63:0] vals[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] r;

    dtm_tap_dmi #(.IDCODE_VALUE(IDC)) dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_op(dmi_resp_op),
        .dmi_hard_reset(dmi_hard_reset)
    );

    always #5 TCK = ~TCK;

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'd0, a, d, op};
    endfunction

    function automatic logic [63:0] req_word(input logic v, input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        return {22'd0, v, op, a, d};
    endfunction

    function automatic logic [63:0] reqs();
        return {22'd0, dmi_req_valid, dmi_req_op, dmi_req_addr, dmi_req_data};
    endfunction

    function automatic logic [63:0] outs();
        return {19'd0, TDO, dmi_req_valid, dmi_resp_ready, dmi_hard_reset, dmi_req_op, dmi_req_addr, dmi_req_data};
    endfunction

    function automatic logic [63:0] hs();
        return {61'd0, dmi_hard_reset, dmi_req_valid, dmi_resp_ready};
    endfunction

    task automatic expect_v(input string tag, input logic [63:0] v);
        tags.push_back(tag);
        vals.push_back(v);
    endtask

    task automatic check(input logic [63:0] got);
        string       t;
        logic [63:0] e;
        checks++;
        if (vals.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty got=%h", got);
        end else begin
            t = tags.pop_front();
            e = vals.pop_front();
            assert (got === e) else begin
                failures++;
                $error("FAIL %s got=%h exp=%h", t, got, e);
            end
        end
    endtask

    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        @(negedge TCK);
        tdo = TDO;
        TMS = tms;
        TDI = tdi;
    endtask

    task automatic idle(input int n);
        logic b;
        repeat (n) tick(1'b0, 1'b0, b);
    endtask

    task automatic to_rti_via_tlr();
        logic b;
        repeat (5) tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic scan_ir(input logic [4:0] code, output logic [63:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tick(i == 4, code[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input logic [63:0] din, input int len, output logic [63:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        for (int i = 0; i < len; i++) begin
            tick(i == len - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
    endtask

    task automatic respond(input logic [1:0] op, input logic [31:0] d);
        dmi_resp_valid = 1'b1;
        dmi_resp_op    = op;
        dmi_resp_data  = d;
        idle(1);
        dmi_resp_valid = 1'b0;
        dmi_resp_op    = 2'd0;
    endtask

    task automatic accept();
        dmi_req_ready = 1'b1;
        idle(1);
        dmi_req_ready = 1'b0;
    endtask

    initial begin
        logic b;
        TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
        dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_op = 2'd0;
        repeat (2) @(negedge TCK);
        expect_v("reset_outs", 64'h0); check(outs());
        TRST = 1'b0;
        to_rti_via_tlr();
        expect_v("idcode", 64'(IDC)); scan_dr(64'h0, 32, r); check(r);
        expect_v("idcode_bit0", 64'h1); check(64'(r[0]));
        expect_v("ir_capture", 64'h01); scan_ir(5'h1F, r); check(r);
        expect_v("bypass", 64'h14A); scan_dr(64'h0A5, 9, r); check(r);
        to_rti_via_tlr();
        expect_v("tlr_idcode", 64'(IDC)); scan_dr(64'h0, 32, r); check(r);
        scan_ir(5'h10, r);
        expect_v("dtmcs_default", 64'h5071); scan_dr(64'h0, 32, r); check(r);
        scan_ir(5'h11, r);
        expect_v("dmi_cap_reset", 64'h0); scan_dr(dmi_word(7'h10, 32'hDEADBEEF, 2'd2), 41, r); check(r);
        idle(1);
        expect_v("wr_req", req_word(1'b1, 2'd2, 7'h10, 32'hDEADBEEF)); check(reqs());
        expect_v("wr_resp_ready_low", 64'h0); check(64'(dmi_resp_ready));
        idle(3);
        expect_v("wr_req_held", req_word(1'b1, 2'd2, 7'h10, 32'hDEADBEEF)); check(reqs());
        accept();
        expect_v("wr_req_done", 64'h1); check(hs());
        respond(2'd0, 32'h0BAD_F00D);
        expect_v("wr_resp_ready_clr", 64'h0); check(hs());
        expect_v("dmi_cap_wr", dmi_word(7'h10, 32'h0BAD_F00D, 2'd0)); scan_dr(dmi_word(7'h11, 32'h0, 2'd1), 41, r); check(r);
        idle(1);
        expect_v("rd_req", req_word(1'b1, 2'd1, 7'h11, 32'h0)); check(reqs());
        accept();
        respond(2'd0, 32'h1234_5678);
        expect_v("dmi_cap_rd", dmi_word(7'h11, 32'h1234_5678, 2'd0)); scan_dr(dmi_word(7'h12, 32'h0, 2'd1), 41, r); check(r);
        idle(1);
        expect_v("busy_req", req_word(1'b1, 2'd1, 7'h12, 32'h0)); check(reqs());
        accept();
        expect_v("busy_cap", dmi_word(7'h12, 32'h1234_5678, 2'd3)); scan_dr(dmi_word(7'h13, 32'h55, 2'd2), 41, r); check(r);
        idle(1);
        expect_v("busy_drop", 64'h0); check(64'(dmi_req_valid));
        scan_ir(5'h10, r);
        expect_v("dtmcs_busy", 64'h5C71); scan_dr(64'h0, 32, r); check(r);
        respond(2'd0, 32'hA5A5_A5A5);
        scan_ir(5'h11, r);
        expect_v("sticky_cap", dmi_word(7'h12, 32'hA5A5_A5A5, 2'd3)); scan_dr(dmi_word(7'h13, 32'h55, 2'd2), 41, r); check(r);
        idle(1);
        expect_v("sticky_drop", 64'h0); check(64'(dmi_req_valid));
        scan_ir(5'h10, r);
        expect_v("dtmcs_pre_dmireset", 64'h5C71); scan_dr(64'h1_0000, 32, r); check(r);
        expect_v("dtmcs_post_dmireset", 64'h5071); scan_dr(64'h0, 32, r); check(r);
        scan_ir(5'h11, r);
        expect_v("cap_post_dmireset", dmi_word(7'h12, 32'hA5A5_A5A5, 2'd0)); scan_dr(dmi_word(7'h14, 32'h77, 2'd2), 41, r); check(r);
        idle(1);
        expect_v("rearm_req", req_word(1'b1, 2'd2, 7'h14, 32'h77)); check(reqs());
        accept();
        respond(2'd2, 32'h0);
        scan_ir(5'h10, r);
        expect_v("dtmcs_failed", 64'h5871); scan_dr(64'h1_0000, 32, r); check(r);
        scan_ir(5'h11, r);
        expect_v("cap_post_fail", dmi_word(7'h14, 32'h0, 2'd0)); scan_dr(dmi_word(7'h15, 32'h99, 2'd2), 41, r); check(r);
        idle(1);
        expect_v("pend_req", req_word(1'b1, 2'd2, 7'h15, 32'h99)); check(reqs());
        expect_v("pend_busy_cap", dmi_word(7'h15, 32'h0, 2'd3)); scan_dr(64'h0, 41, r); check(r);
        scan_ir(5'h10, r);
        expect_v("dtmcs_pend", 64'h5C71); scan_dr(64'h2_0000, 32, r); check(r);
        idle(1);
        expect_v("hard_pulse", 64'h4); check(hs());
        idle(1);
        expect_v("hard_pulse_end", 64'h0); check(hs());
        expect_v("dtmcs_post_hard", 64'h5071); scan_dr(64'h0, 32, r); check(r);
        scan_ir(5'h11, r);
        expect_v("pre_trst_cap", dmi_word(7'h15, 32'h0, 2'd0)); scan_dr(dmi_word(7'h16, 32'h1234, 2'd2), 41, r); check(r);
        idle(1);
        expect_v("pre_trst_req", req_word(1'b1, 2'd2, 7'h16, 32'h1234)); check(reqs());
        tick(1'b1, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b0, b);
        expect_v("tdo_busy_bit", 64'h1); check(64'(b));
        #2 TRST = 1'b1;
        #1 expect_v("trst_outs", 64'h0); check(outs());
        @(negedge TCK);
        TRST = 1'b0;
        tick(1'b0, 1'b0, b);
        expect_v("trst_idcode", 64'(IDC)); scan_dr(64'h0, 32, r); check(r);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
